// File: rtl/escalonador_rr.sv
// Round-robin process scheduler with a per-slot context table.
//
// Slot 0 is the operating system (SO). User slots are 1..NUM_PROC. Each slot
// has a valid flag and a saved resume PC. When the SO reports that a context
// switch is done, the scheduler picks the next valid slot after the last one
// dispatched, wrapping around, and asks the PC register to load that slot's
// PC. Preemption (a rising edge on swap_SO) saves the running slot's PC.
// Termination (proc_fim) frees the slot. Both hand the CPU back to the SO.
//
// Ports
//   clk, reset_n      clock; asynchronous active-low reset
//   swap_SO           preemption request (level; its rising edge is detected)
//   ultimo_pc         resume PC of the process being preempted
//   proc_fim          running user process terminated (1-cycle pulse)
//   so_pronto         SO switch routine done, dispatch allowed
//   proc_criar*       create request: valid strobe, slot id, start PC
//   idProc            id of the process owning the CPU (0 = SO)
//   pc_retomada       PC to load into the PC register
//   carrega_pc        1-cycle pulse, PC register loads pc_retomada
//   erro_criar        1-cycle pulse, create request rejected
module escalonador_rr #(
  parameter int unsigned NUM_PROC = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        swap_SO,
  input  logic [31:0] ultimo_pc,
  input  logic        proc_fim,
  input  logic        so_pronto,
  input  logic        proc_criar,
  input  logic [4:0]  proc_criar_id,
  input  logic [31:0] proc_criar_pc,
  output logic [4:0]  idProc,
  output logic [31:0] pc_retomada,
  output logic        carrega_pc,
  output logic        erro_criar
);

  typedef enum logic [2:0] {
    StSo,
    StSalva,
    StEscolhe,
    StDespacha,
    StExec
  } state_e;

  state_e      state_q;
  logic [NUM_PROC:1] valido_q;
  logic [31:0] pc_salvo_q [1:NUM_PROC];
  logic [4:0]  ultimo_id_q;
  // Holds the latched choice from ESCOLHE while dispatching and running.
  logic [4:0]  id_proc_q;
  logic [31:0] pc_retomada_q;
  logic        carrega_pc_q;
  logic        erro_criar_q;
  logic        swap_prev_q;

  logic        swap_rise;
  logic        any_valid;
  logic        create_ok;
  logic        found_hi;
  logic [4:0]  pick_hi;
  logic [4:0]  pick_lo;
  logic [4:0]  pick_id;
  logic [31:0] pick_pc;

  assign swap_rise = swap_SO & ~swap_prev_q;
  assign any_valid = |valido_q;

  // A slot that is still valid is rejected; this also covers a create aimed
  // at the slot being freed by proc_fim in the same cycle.
  always_comb begin
    create_ok = 1'b0;
    for (int j = 1; j <= int'(NUM_PROC); j++) begin
      if (proc_criar_id == 5'(j) && !valido_q[j]) begin
        create_ok = proc_criar;
      end
    end
  end

  // Round-robin: lowest valid id above ultimo_id, else lowest valid id at or
  // below it (which may be ultimo_id itself when it is the only one).
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int j = int'(NUM_PROC); j >= 1; j--) begin
      if (valido_q[j]) begin
        if (5'(j) > ultimo_id_q) begin
          pick_hi  = 5'(j);
          found_hi = 1'b1;
        end else begin
          pick_lo = 5'(j);
        end
      end
    end
    pick_id = found_hi ? pick_hi : pick_lo;
    pick_pc = '0;
    for (int j = 1; j <= int'(NUM_PROC); j++) begin
      if (pick_id == 5'(j)) begin
        pick_pc = pc_salvo_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StSo;
      valido_q      <= '0;
      for (int j = 1; j <= int'(NUM_PROC); j++) begin
        pc_salvo_q[j] <= '0;
      end
      ultimo_id_q   <= 5'(NUM_PROC);
      id_proc_q     <= '0;
      pc_retomada_q <= RESET_PC;
      carrega_pc_q  <= 1'b0;
      erro_criar_q  <= 1'b0;
      swap_prev_q   <= 1'b0;
    end else begin
      carrega_pc_q <= 1'b0;
      erro_criar_q <= proc_criar & ~create_ok;
      swap_prev_q  <= swap_SO;

      for (int j = 1; j <= int'(NUM_PROC); j++) begin
        if (create_ok && proc_criar_id == 5'(j)) begin
          valido_q[j]   <= 1'b1;
          pc_salvo_q[j] <= proc_criar_pc;
        end
      end

      unique case (state_q)
        StSo: begin
          if (so_pronto && any_valid) begin
            state_q <= StEscolhe;
          end
        end
        StEscolhe: begin
          if (any_valid) begin
            id_proc_q     <= pick_id;
            ultimo_id_q   <= pick_id;
            pc_retomada_q <= pick_pc;
            carrega_pc_q  <= 1'b1;
            state_q       <= StDespacha;
          end else begin
            state_q <= StSo;
          end
        end
        StDespacha: begin
          state_q <= StExec;
        end
        StExec: begin
          // Termination wins over a simultaneous preemption edge.
          if (proc_fim) begin
            for (int j = 1; j <= int'(NUM_PROC); j++) begin
              if (id_proc_q == 5'(j)) begin
                valido_q[j] <= 1'b0;
              end
            end
            id_proc_q     <= '0;
            pc_retomada_q <= RESET_PC;
            carrega_pc_q  <= 1'b1;
            state_q       <= StSo;
          end else if (swap_rise) begin
            state_q <= StSalva;
          end
        end
        StSalva: begin
          for (int j = 1; j <= int'(NUM_PROC); j++) begin
            if (id_proc_q == 5'(j)) begin
              pc_salvo_q[j] <= ultimo_pc;
            end
          end
          id_proc_q     <= '0;
          pc_retomada_q <= RESET_PC;
          carrega_pc_q  <= 1'b1;
          state_q       <= StSo;
        end
        default: begin
          state_q <= StSo;
        end
      endcase
    end
  end

  assign idProc      = id_proc_q;
  assign pc_retomada = pc_retomada_q;
  assign carrega_pc  = carrega_pc_q;
  assign erro_criar  = erro_criar_q;

endmodule

// File: tb/tb_escalonador_rr.sv
module tb_escalonador_rr;

  localparam logic [31:0] RST = 32'h0000_0F00;

  logic        clk;
  logic        reset_n;
  logic        swap_SO;
  logic [31:0] ultimo_pc;
  logic        proc_fim;
  logic        so_pronto;
  logic        proc_criar;
  logic [4:0]  proc_criar_id;
  logic [31:0] proc_criar_pc;
  logic [4:0]  idProc;
  logic [31:0] pc_retomada;
  logic        carrega_pc;
  logic        erro_criar;

  escalonador_rr #(
    .NUM_PROC(4),
    .RESET_PC(RST)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .swap_SO      (swap_SO),
    .ultimo_pc    (ultimo_pc),
    .proc_fim     (proc_fim),
    .so_pronto    (so_pronto),
    .proc_criar   (proc_criar),
    .proc_criar_id(proc_criar_id),
    .proc_criar_pc(proc_criar_pc),
    .idProc       (idProc),
    .pc_retomada  (pc_retomada),
    .carrega_pc   (carrega_pc),
    .erro_criar   (erro_criar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output events (PC loads and create errors), in order.
  typedef struct packed {
    logic        is_err;
    logic [4:0]  id;
    logic [31:0] pc;
  } ev_t;

  // Expected full output snapshot at the next falling edge.
  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] pc;
    logic        ld;
    logic        er;
  } probe_t;

  ev_t    ev_q[$];
  probe_t probe_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     end_req = 1'b0;
  bit     end_done = 1'b0;

  always @(negedge clk) begin
    if (probe_q.size() != 0) begin
      probe_t p;
      p = probe_q.pop_front();
      checks++;
      if (idProc !== p.id || pc_retomada !== p.pc || carrega_pc !== p.ld ||
          erro_criar !== p.er) begin
        errors++;
        $display("FAIL probe t=%0t got id=%0d pc=%0h ld=%0b er=%0b required id=%0d pc=%0h ld=%0b er=%0b",
                 $time, idProc, pc_retomada, carrega_pc, erro_criar, p.id, p.pc, p.ld, p.er);
      end
    end
    if (carrega_pc === 1'b1) begin
      checks++;
      if (ev_q.size() == 0 || ev_q[0].is_err) begin
        errors++;
        $display("FAIL load t=%0t got id=%0d pc=%0h required no load", $time, idProc,
                 pc_retomada);
        if (ev_q.size() != 0) void'(ev_q.pop_front());
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        if (idProc !== e.id || pc_retomada !== e.pc) begin
          errors++;
          $display("FAIL load t=%0t got id=%0d pc=%0h required id=%0d pc=%0h", $time, idProc,
                   pc_retomada, e.id, e.pc);
        end
      end
    end
    if (erro_criar === 1'b1) begin
      checks++;
      if (ev_q.size() == 0 || !ev_q[0].is_err) begin
        errors++;
        $display("FAIL erro_criar t=%0t got pulse required none", $time);
      end else begin
        void'(ev_q.pop_front());
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (ev_q.size() != 0 || probe_q.size() != 0) begin
        errors++;
        $display("FAIL pending got %0d events %0d probes required 0 0", ev_q.size(),
                 probe_q.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [4:0] id, input logic [31:0] pc, input logic ld,
                       input logic er);
    probe_q.push_back({id, pc, ld, er});
  endtask

  task automatic expect_load(input logic [4:0] id, input logic [31:0] pc);
    ev_q.push_back({1'b0, id, pc});
  endtask

  task automatic expect_err();
    ev_q.push_back({1'b1, 5'd0, 32'd0});
  endtask

  task automatic create(input logic [4:0] id, input logic [31:0] pc, input bit rejected);
    proc_criar    = 1'b1;
    proc_criar_id = id;
    proc_criar_pc = pc;
    if (rejected) expect_err();
    tick();
    proc_criar = 1'b0;
  endtask

  // so_pronto in SO -> ESCOLHE -> DESPACHA (load visible) -> EXEC.
  task automatic dispatch(input logic [4:0] id, input logic [31:0] pc);
    so_pronto = 1'b1;
    expect_load(id, pc);
    tick();
    so_pronto = 1'b0;
    tick();
    probe(id, pc, 1'b1, 1'b0);
    tick();
  endtask

  task automatic preempt(input logic [31:0] upc);
    ultimo_pc = upc;
    swap_SO   = 1'b1;
    expect_load(5'd0, RST);
    tick();
    tick();
    swap_SO = 1'b0;
    probe(5'd0, RST, 1'b1, 1'b0);
    tick();
  endtask

  task automatic finish_proc();
    proc_fim = 1'b1;
    expect_load(5'd0, RST);
    tick();
    proc_fim = 1'b0;
    probe(5'd0, RST, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    swap_SO       = 1'b0;
    ultimo_pc     = '0;
    proc_fim      = 1'b0;
    so_pronto     = 1'b0;
    proc_criar    = 1'b0;
    proc_criar_id = '0;
    proc_criar_pc = '0;
    #1;
    probe(5'd0, RST, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    probe(5'd0, RST, 1'b0, 1'b0);

    // First dispatch and its latency.
    create(5'd1, 32'd100, 1'b0);
    dispatch(5'd1, 32'd100);

    // Termination and preemption edge together; then no valid slot left.
    proc_fim = 1'b1;
    swap_SO  = 1'b1;
    expect_load(5'd0, RST);
    tick();
    proc_fim = 1'b0;
    swap_SO  = 1'b0;
    probe(5'd0, RST, 1'b1, 1'b0);
    tick();
    so_pronto = 1'b1;
    tick();
    so_pronto = 1'b0;
    tick();
    tick();
    probe(5'd0, RST, 1'b0, 1'b0);
    tick();

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Create rejections: duplicate, id 0, id above NUM_PROC.
    create(5'd1, 32'd10, 1'b0);
    create(5'd1, 32'd20, 1'b1);
    create(5'd0, 32'd30, 1'b1);
    create(5'd5, 32'd40, 1'b1);
    create(5'd2, 32'd200, 1'b0);
    create(5'd3, 32'd300, 1'b0);
    dispatch(5'd1, 32'd10);
    preempt(32'd110);
    dispatch(5'd2, 32'd200);

    // swap_SO held high for 10 cycles: one save, no retrigger in EXEC.
    ultimo_pc = 32'd222;
    swap_SO   = 1'b1;
    expect_load(5'd0, RST);
    tick();
    tick();
    probe(5'd0, RST, 1'b1, 1'b0);
    so_pronto = 1'b1;
    expect_load(5'd3, 32'd300);
    tick();
    so_pronto = 1'b0;
    tick();
    probe(5'd3, 32'd300, 1'b1, 1'b0);
    tick();
    repeat (5) tick();
    probe(5'd3, 32'd300, 1'b0, 1'b0);
    swap_SO = 1'b0;
    tick();

    // Save of slot 3 and wrap-around selection; saved PCs come back.
    preempt(32'd250);
    dispatch(5'd1, 32'd110);
    preempt(32'd111);
    dispatch(5'd2, 32'd222);
    preempt(32'd333);
    dispatch(5'd3, 32'd250);

    // Create into the slot freed by proc_fim in the same cycle.
    proc_fim      = 1'b1;
    proc_criar    = 1'b1;
    proc_criar_id = 5'd3;
    proc_criar_pc = 32'd999;
    expect_load(5'd0, RST);
    expect_err();
    tick();
    proc_fim   = 1'b0;
    proc_criar = 1'b0;
    probe(5'd0, RST, 1'b1, 1'b1);
    tick();
    dispatch(5'd1, 32'd111);
    finish_proc();

    // Single valid slot re-selected after preemption.
    dispatch(5'd2, 32'd333);
    preempt(32'd444);
    dispatch(5'd2, 32'd444);
    preempt(32'd555);

    // Reset asserted while in DESPACHA.
    so_pronto = 1'b1;
    tick();
    so_pronto = 1'b0;
    tick();
    #1;
    reset_n = 1'b0;
    probe(5'd0, RST, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    so_pronto = 1'b1;
    tick();
    so_pronto = 1'b0;
    tick();
    tick();
    probe(5'd0, RST, 1'b0, 1'b0);
    tick();
    create(5'd2, 32'd777, 1'b0);
    dispatch(5'd2, 32'd777);

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if (!end_done) begin
      errors++;
      $display("FAIL end_check got not done required done");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escalonador_rr.md
ESCALONADOR_RR -- requirements
Module: escalonador_rr

Interface
REQ-001 SHALL have parameter NUM_PROC, default 4, meaning user process slots with idProc 1..NUM_PROC; idProc 0 is the SO.
REQ-002 SHALL have parameter RESET_PC, default 32'd0, meaning SO entry PC driven on pc_retomada after reset.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port swap_SO  input  1  preemption request from the quantum counter, level, sampled each posedge.
REQ-006 SHALL have port ultimo_pc  input  32  resume PC of the preempted process.
REQ-007 SHALL have port proc_fim  input  1  running user process terminated, 1-cycle pulse.
REQ-008 SHALL have port so_pronto  input  1  SO context-switch routine finished, dispatch allowed.
REQ-009 SHALL have ports proc_criar  input  1, proc_criar_id  input  5, proc_criar_pc  input  32  create process request, slot id, start PC.
REQ-010 SHALL have port idProc  output  5  id of the process owning the CPU.
REQ-011 SHALL have port pc_retomada  output  32  PC to load into the PC register.
REQ-012 SHALL have port carrega_pc  output  1  1-cycle pulse, PC register loads pc_retomada.
REQ-013 SHALL have port erro_criar  output  1  1-cycle pulse, create request rejected.

Function
REQ-014 SHALL hold per-slot table: valido[1..NUM_PROC] and pc_salvo[1..NUM_PROC] (32 bit).
REQ-015 SHALL implement FSM states SO, SALVA, ESCOLHE, DESPACHA, EXEC.
REQ-016 SO: idProc=0; when so_pronto=1 and at least one valido slot exists -> ESCOLHE; else remain SO.
REQ-017 ESCOLHE: SHALL pick, in one cycle, the first valido slot searching ids ultimo_id+1 .. NUM_PROC then 1 .. ultimo_id (round-robin, wrap-around), latch it in prox_id -> DESPACHA; if none valido -> SO.
REQ-018 DESPACHA: pc_retomada=pc_salvo[prox_id], carrega_pc=1 for exactly this cycle, idProc=prox_id, ultimo_id=prox_id -> EXEC.
REQ-019 EXEC: on rising edge of swap_SO (swap_SO=1, previous sample 0) -> SALVA; swap_SO held high SHALL NOT retrigger.
REQ-020 SALVA: pc_salvo[idProc]=ultimo_pc; idProc=0; pc_retomada=RESET_PC; carrega_pc=1 -> SO.
REQ-021 EXEC with proc_fim=1: valido[idProc]=0, idProc=0, pc_retomada=RESET_PC, carrega_pc=1 -> SO; no save.
REQ-022 proc_fim and swap_SO rising in same cycle: proc_fim SHALL win (REQ-021), swap edge discarded.
REQ-023 swap_SO and proc_fim SHALL be ignored outside EXEC.
REQ-024 proc_criar accepted in any state when 1<=proc_criar_id<=NUM_PROC and slot not valido: valido=1, pc_salvo=proc_criar_pc, effective next cycle.
REQ-025 proc_criar with id 0, id>NUM_PROC or slot already valido SHALL not modify the table and SHALL pulse erro_criar next cycle.
REQ-026 proc_criar to the slot freed by proc_fim in the same cycle SHALL be rejected (erro_criar).
REQ-027 Dispatch latency: so_pronto sampled in SO -> carrega_pc high exactly 2 cycles later.
REQ-028 A single valid process SHALL be re-selected after each preemption (wrap to itself).

Reset
REQ-029 reset_n=0 SHALL immediately force state SO, idProc=0, pc_retomada=RESET_PC, carrega_pc=0, erro_criar=0, all valido=0, pc_salvo=0, ultimo_id=NUM_PROC, swap_SO edge register=0.
REQ-030 Reset asserted mid-dispatch or mid-save SHALL abort with no table update; after release FSM starts in SO.

Verification
REQ-031 Reset, create id1 pc=100, so_pronto -> 2 cycles later carrega_pc=1, pc_retomada=100, idProc=1.
REQ-032 ids 1,2,3 valid, running 3, swap_SO edge with ultimo_pc=250 -> pc_salvo[3]=250, idProc=0; next dispatch selects id1 (wrap).
REQ-033 Running id2, swap_SO held high 10 cycles -> exactly one SALVA, one save.
REQ-034 Running id1, proc_fim and swap_SO edge same cycle -> valido[1]=0, pc_salvo[1] unchanged, idProc=0; so_pronto with no valid slot -> stays SO, no carrega_pc.
REQ-035 Create id1 twice, create id0, create id5 (NUM_PROC=4) -> three erro_criar pulses, table holds first id1 only.
REQ-036 reset_n low during DESPACHA -> outputs at reset values asynchronously, all valido=0.
